bus_host_arbiter: RTL
=====================

// Module: bus_host_arbiter
//
// PURPOSE
// - Shares one downstream bus device port between NrHosts requesters (core data port, debug SBA host).
// - Uses the req/gnt/rvalid protocol of the system bus. Sits between the hosts and the bus host port.
// - Arbitrates round-robin, locks the winner until it is granted, and queues the granted host index.
// - Each rvalid/rdata/err response is routed back to the host that issued the request, in issue order.
//
// PARAMETERS
// - NrHosts         2   number of requesters, >=2
// - DataWidth       32  data and wdata/rdata width
// - AddressWidth    32  address width
// - MaxOutstanding  2   accepted-but-unanswered transactions allowed; response FIFO depth, >=1
//
// PORTS
// - clk_i           in   1                   system clock
// - rst_i           in   1                   synchronous reset, active-high
// - host_req_i      in   NrHosts             per-host request
// - host_gnt_o      out  NrHosts             per-host grant (one-hot or zero)
// - host_addr_i     in   NrHosts*AddressWidth  per-host address, packed, host 0 in LSBs
// - host_we_i       in   NrHosts             per-host write enable
// - host_be_i       in   NrHosts*4           per-host byte enables
// - host_wdata_i    in   NrHosts*DataWidth   per-host write data
// - host_rvalid_o   out  NrHosts             per-host response valid (one-hot or zero)
// - host_rdata_o    out  DataWidth           response data, broadcast to all hosts
// - host_err_o      out  NrHosts             per-host error, qualified by host_rvalid_o
// - dev_req_o       out  1                   downstream request
// - dev_gnt_i       in   1                   downstream grant
// - dev_addr_o      out  AddressWidth        downstream address
// - dev_we_o        out  1                   downstream write enable
// - dev_be_o        out  4                   downstream byte enables
// - dev_wdata_o     out  DataWidth           downstream write data
// - dev_rvalid_i    in   1                   downstream response valid
// - dev_rdata_i     in   DataWidth           downstream response data
// - dev_err_i       in   1                   downstream response error
//
// BEHAVIOUR
// - Reset state:
//   - rr pointer = 0, lock cleared, FIFO empty (count = 0).
//   - All outputs are 0 in the reset cycle, then follow the combinational rules below.
// - Eligibility:
//   - can_issue = (count < MaxOutstanding) | dev_rvalid_i. A pop in the same cycle frees a slot.
//   - dev_req_o = can_issue & (lock ? 1 : |host_req_i).
// - Winner selection:
//   - Unlocked: the first requesting host at or after the rr pointer, searching with modulo-NrHosts wrap.
//   - Locked: the stored lock index. Hosts hold req until gnt, so the locked winner stays valid.
// - States, per cycle:
//   - IDLE   : no request, nothing changes.
//   - OFFER  : dev_req_o=1 & !dev_gnt_i -> set lock = winner; the winner stays fixed until accepted.
//   - ACCEPT : dev_req_o=1 & dev_gnt_i  -> host_gnt_o[winner]=1 in the same cycle.
//     - Push winner into the FIFO.
//     - Clear lock.
//     - rr pointer <= (winner+1) mod NrHosts.
// - Data path:
//   - dev_addr/we/be/wdata are muxed combinationally from the winner. Zero-latency pass-through.
// - Response routing:
//   - On dev_rvalid_i with the FIFO non-empty: host_rvalid_o[head]=1 and host_err_o[head]=dev_err_i in the same cycle; pop.
//   - host_rdata_o = dev_rdata_i at all times.
// - Boundaries:
//   - Push and pop in the same cycle: count is unchanged, order is preserved.
//   - FIFO full and no rvalid: dev_req_o=0 and all host_gnt_o=0. The lock is held.
//   - dev_rvalid_i with the FIFO empty: the response is dropped (no host_rvalid_o). A simulation assertion fires.
//   - rr pointer wrap: after host NrHosts-1 wins, the pointer goes to 0.
//   - Reset mid-transaction: the FIFO is flushed. Responses arriving afterwards are dropped as unexpected.
// - Width rules:
//   - The index is $clog2(NrHosts) bits.
//   - count is $clog2(MaxOutstanding+1) bits and never exceeds MaxOutstanding.
//
// CONFIGURATION
// - BUS_ARB_FIXED_PRIO_EN defined:
//   - Unlocked winner = lowest-index requesting host.
//   - The rr pointer is removed. Locking and FIFO behaviour are unchanged.
// - Undefined (default): round-robin as described above.
//
// TESTING
// - Single host: host0 write to 0x8000_0000, dev_gnt_i=1 -> host_gnt_o=01 the same cycle; dev_rvalid_i next cycle -> host_rvalid_o=01.
// - Contention: both hosts hold req, dev_gnt_i=1 every cycle -> grants alternate 01,10,01,10.
//   - With BUS_ARB_FIXED_PRIO_EN the grants are 01,01,01.
// - Lock: host1 wins, dev_gnt_i=0 for 3 cycles, host0 raises req -> dev_addr_o stays host1's; the first grant goes to 10.
// - Outstanding: MaxOutstanding=2, two accepts, no rvalid -> dev_req_o=0.
//   - Then rvalid, dev_gnt_i=1 and rdata=0xDEAD_BEEF in the same cycle -> pop to the first host and accept the third request; count stays 2.
// - Ordering/err: accept host0 then host1, return err=0 then err=1 -> host_rvalid_o 01 (err 0), then 10 with host_err_o[1]=1.
// - Reset: rst_i pulses with 2 outstanding, then a stray dev_rvalid_i -> no host_rvalid_o, count=0, next grant goes to host0.

Source files
------------

// File: rtl/bus_host_arbiter.sv
// Module: bus_host_arbiter
// Shares one downstream bus device port between NrHosts requesters using
// the req/gnt/rvalid protocol. A winner is chosen round-robin, held until the
// device grants it, and its index is queued so that each response is routed
// back to the issuing host in issue order.
// Optional macro BUS_ARB_FIXED_PRIO_EN: lowest-index requester always wins
// when unlocked and the round-robin pointer is removed.
module bus_host_arbiter #(
  parameter int NrHosts        = 2,
  parameter int DataWidth      = 32,
  parameter int AddressWidth   = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NrHosts-1:0]                host_req_i,
  output logic [NrHosts-1:0]                host_gnt_o,
  input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
  input  logic [NrHosts-1:0]                host_we_i,
  input  logic [NrHosts*4-1:0]              host_be_i,
  input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
  output logic [NrHosts-1:0]                host_rvalid_o,
  output logic [DataWidth-1:0]              host_rdata_o,
  output logic [NrHosts-1:0]                host_err_o,
  output logic                              dev_req_o,
  input  logic                              dev_gnt_i,
  output logic [AddressWidth-1:0]           dev_addr_o,
  output logic                              dev_we_o,
  output logic [3:0]                        dev_be_o,
  output logic [DataWidth-1:0]              dev_wdata_o,
  input  logic                              dev_rvalid_i,
  input  logic [DataWidth-1:0]              dev_rdata_i,
  input  logic                              dev_err_i
);

  localparam int IdxW = $clog2(NrHosts);
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef enum logic {
    ST_FREE,
    ST_LOCKED
  } lock_state_e;

  lock_state_e     state_q, state_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic [IdxW-1:0] winner;
  logic [IdxW-1:0] winner_next;
  logic [IdxW-1:0] fifo_q [MaxOutstanding];
  logic [IdxW-1:0] head;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            can_issue;
  logic            dev_req;
  logic            accept;
  logic            offer;
  logic            pop;

`ifndef BUS_ARB_FIXED_PRIO_EN
  logic [IdxW-1:0] rr_q;
`endif

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop in the same cycle frees a slot, so a returning response lets a new request issue.
  assign can_issue   = (count_q < CntW'(MaxOutstanding)) | dev_rvalid_i;
  assign dev_req     = !rst_i && can_issue && ((state_q == ST_LOCKED) || (|host_req_i));
  assign accept      = dev_req && dev_gnt_i;
  assign offer       = dev_req && !dev_gnt_i;
  assign pop         = !rst_i && dev_rvalid_i && (count_q != '0);
  assign head        = fifo_q[rd_ptr_q];
  assign winner_next = (winner == IdxW'(NrHosts - 1)) ? '0 : winner + 1'b1;

  // Winner selection: the locked index while an offer is pending, otherwise the arbitration result.
  always_comb begin
`ifndef BUS_ARB_FIXED_PRIO_EN
    int   cand;
    logic found;
    found = 1'b0;
    cand  = 0;
`endif
    winner = '0;
    if (state_q == ST_LOCKED) begin
      winner = lock_idx_q;
    end else begin
`ifdef BUS_ARB_FIXED_PRIO_EN
      for (int i = NrHosts - 1; i >= 0; i--) begin
        if (host_req_i[i]) winner = IdxW'(i);
      end
`else
      winner = rr_q;
      for (int i = 0; i < NrHosts; i++) begin
        cand = int'(rr_q) + i;
        if (cand >= NrHosts) cand = cand - NrHosts;
        if (!found && host_req_i[cand]) begin
          winner = IdxW'(cand);
          found  = 1'b1;
        end
      end
`endif
    end
  end

  // Lock state register: an offered-but-ungranted winner is held across cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_FREE;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Lock next state: lock on an unanswered offer, release on grant, otherwise hold.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    if (accept) begin
      state_d = ST_FREE;
    end else if (offer) begin
      state_d    = ST_LOCKED;
      lock_idx_d = winner;
    end
  end

`ifndef BUS_ARB_FIXED_PRIO_EN
  // Round-robin pointer moves just past each accepted winner.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else if (accept) begin
      rr_q <= winner_next;
    end
  end
`else
  // Fixed priority does not rotate, so the successor index is not needed.
  logic unused_winner_next;
  assign unused_winner_next = ^winner_next;
`endif

  // Response FIFO of granted host indices; push and pop together keep the count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept) begin
        fifo_q[wr_ptr_q] <= winner;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (accept && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !accept) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // A response with nothing outstanding is dropped; flag it in simulation.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      unexpected_rsp : assert (!(dev_rvalid_i && (count_q == '0)))
        else $warning("bus_host_arbiter: unexpected response dropped");
    end
  end

  // Outputs: grant and data mux from the winner, response routed to the FIFO head, all zero in reset.
  always_comb begin
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    host_err_o    = '0;
    host_rdata_o  = '0;
    dev_req_o     = 1'b0;
    dev_addr_o    = '0;
    dev_we_o      = 1'b0;
    dev_be_o      = '0;
    dev_wdata_o   = '0;
    if (!rst_i) begin
      dev_req_o          = dev_req;
      dev_addr_o         = host_addr_i[winner*AddressWidth +: AddressWidth];
      dev_we_o           = host_we_i[winner];
      dev_be_o           = host_be_i[winner*4 +: 4];
      dev_wdata_o        = host_wdata_i[winner*DataWidth +: DataWidth];
      host_rdata_o       = dev_rdata_i;
      host_gnt_o[winner] = accept;
      if (pop) begin
        host_rvalid_o[head] = 1'b1;
        host_err_o[head]    = dev_err_i;
      end
    end
  end

endmodule
